// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, presents it to instruction memory and
// registers the returned word, with branch redirect, stall and text-segment wrap.
module instruction_fetch_unit #(
  parameter int                 WIDTH        = 32,
  parameter int                 MEMORY_DEPTH = 64,
  parameter logic [WIDTH-1:0]   RESET_PC     = 32'h00400000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic [WIDTH-1:0] Instruction_i,
  output logic [WIDTH-1:0] Address_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             fetch_valid_o,
  output logic             misaligned_o,
  output logic [15:0]      fetch_count_o
);

  // Address of the final word in the text segment; stepping past it wraps to the base.
  localparam logic [WIDTH-1:0] LAST_PC = RESET_PC + WIDTH'(4 * (MEMORY_DEPTH - 1));

  logic [WIDTH-1:0] pc_q;

  assign Address_o  = pc_q;
  assign pc_plus4_o = pc_o + WIDTH'(4);

  // Branch beats stall, stall beats a normal fetch; a branch squashes the word at Address_o.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      instr_o       <= '0;
      pc_o          <= '0;
      fetch_valid_o <= 1'b0;
      misaligned_o  <= 1'b0;
      fetch_count_o <= '0;
    end else if (branch_en_i) begin
      pc_q          <= {branch_target_i[WIDTH-1:2], 2'b00};
      fetch_valid_o <= 1'b0;
      if (branch_target_i[1:0] != 2'b00)
        misaligned_o <= 1'b1;
    end else if (!stall_i) begin
      instr_o       <= Instruction_i;
      pc_o          <= pc_q;
      fetch_valid_o <= 1'b1;
      if (fetch_count_o != 16'hFFFF)
        fetch_count_o <= fetch_count_o + 16'd1;
      if (pc_q == LAST_PC)
        pc_q <= RESET_PC;
      else
        pc_q <= pc_q + WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// random stall/branch traffic compared against a behavioural fetch model.
module tb_instruction_fetch_unit;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h00400000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        branch_en_i;
  logic [31:0] branch_target_i;
  logic [31:0] Instruction_i;
  logic [31:0] Address_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        misaligned_o;
  logic [15:0] fetch_count_o;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] mPc, mInstr, mPcOut;
  logic        mValid, mMis;
  logic [15:0] mCount;

  instruction_fetch_unit #(.WIDTH(WIDTH), .MEMORY_DEPTH(DEPTH), .RESET_PC(BASE)) dut (
    .clock(clock),
    .reset(reset),
    .stall_i(stall_i),
    .branch_en_i(branch_en_i),
    .branch_target_i(branch_target_i),
    .Instruction_i(Instruction_i),
    .Address_o(Address_o),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o),
    .fetch_valid_o(fetch_valid_o),
    .misaligned_o(misaligned_o),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clock = ~clock;

  // Text segment word i holds 32'h1000+i; anything else returns an address-derived pattern.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (addr[1:0] == 2'b00 && addr >= BASE && off < 32'(4 * DEPTH))
      return 32'h1000 + (off >> 2);
    return addr ^ 32'hA5A55A5A;
  endfunction

  always_comb Instruction_i = memWord(Address_o);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPc = BASE; mInstr = '0; mPcOut = '0; mValid = 1'b0; mMis = 1'b0; mCount = '0;
  endtask

  task automatic modelStep(input logic stall, input logic branch, input logic [31:0] target);
    logic [31:0] cur;
    cur = mPc;
    if (branch) begin
      mPc    = target & ~32'h3;
      mValid = 1'b0;
      if (target % 4 != 0) mMis = 1'b1;
    end else if (!stall) begin
      mInstr = memWord(cur);
      mPcOut = cur;
      mValid = 1'b1;
      if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
      mPc = (cur == BASE + 32'(4 * (DEPTH - 1))) ? BASE : cur + 32'd4;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".addr"},  Address_o, mPc);
    checkOutput({tag, ".instr"}, instr_o, mInstr);
    checkOutput({tag, ".pc"},    pc_o, mPcOut);
    checkOutput({tag, ".pc4"},   pc_plus4_o, mPcOut + 32'd4);
    checkOutput({tag, ".valid"}, 32'(fetch_valid_o), 32'(mValid));
    checkOutput({tag, ".mis"},   32'(misaligned_o), 32'(mMis));
    checkOutput({tag, ".count"}, 32'(fetch_count_o), 32'(mCount));
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks just after the rising edge.
  task automatic applyStimulus(input logic stall, input logic branch, input logic [31:0] target, input string tag);
    stall_i         = stall;
    branch_en_i     = branch;
    branch_target_i = target;
    @(posedge clock);
    modelStep(stall, branch, target);
    #1;
    checkAll(tag);
    @(negedge clock);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear before the next rising edge.
  task automatic doReset(input string tag);
    #2;
    reset = 1'b1;
    stall_i = 1'b0; branch_en_i = 1'b0; branch_target_i = '0;
    modelReset();
    #1;
    checkAll(tag);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] target;
    int          pick;
    reset = 1'b1; stall_i = 1'b0; branch_en_i = 1'b0; branch_target_i = '0;
    modelReset();
    @(negedge clock);
    doReset("reset");
    checkOutput("reset.addr_const", Address_o, 32'h00400000);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, "seq");
    checkOutput("seq.addr_const",  Address_o, 32'h0040000C);
    checkOutput("seq.instr_const", instr_o, 32'h1002);
    checkOutput("seq.count_const", 32'(fetch_count_o), 32'd3);

    doReset("reset2");
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, '0, "prestall");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0, "stall");
    checkOutput("stall.addr_const", Address_o, 32'h00400008);
    checkOutput("stall.pc_const",   pc_o, 32'h00400004);
    checkOutput("stall.count_const", 32'(fetch_count_o), 32'd2);
    applyStimulus(1'b0, 1'b0, '0, "resume");
    checkOutput("resume.pc_const", pc_o, 32'h00400008);

    applyStimulus(1'b1, 1'b1, 32'h00400020, "brstall");
    checkOutput("brstall.addr_const", Address_o, 32'h00400020);
    checkOutput("brstall.valid_const", 32'(fetch_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, "brfetch");
    checkOutput("brfetch.pc_const", pc_o, 32'h00400020);
    checkOutput("brfetch.valid_const", 32'(fetch_valid_o), 32'd1);

    applyStimulus(1'b0, 1'b1, 32'h004000FC, "tolast");
    applyStimulus(1'b0, 1'b0, '0, "wrap");
    checkOutput("wrap.pc_const",   pc_o, 32'h004000FC);
    checkOutput("wrap.addr_const", Address_o, 32'h00400000);
    checkOutput("wrap.instr_const", instr_o, 32'h103F);

    applyStimulus(1'b0, 1'b1, 32'h00400013, "misbr");
    checkOutput("misbr.addr_const", Address_o, 32'h00400010);
    checkOutput("misbr.mis_const", 32'(misaligned_o), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0, "misrun");
    checkOutput("misrun.mis_const", 32'(misaligned_o), 32'd1);

    applyStimulus(1'b0, 1'b1, 32'h12345678, "outseg");
    applyStimulus(1'b0, 1'b0, '0, "outseg_step");
    checkOutput("outseg.addr_const", Address_o, 32'h1234567C);

    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, "top");
    applyStimulus(1'b0, 1'b0, '0, "top_step");
    checkOutput("top.pc4_const", pc_plus4_o, 32'h00000000);

    doReset("reset3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, "prereset");
    checkOutput("prereset.addr_const", Address_o, 32'h0040000C);
    doReset("async");
    checkOutput("async.count_const", 32'(fetch_count_o), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, "postreset");
    checkOutput("postreset.count_const", 32'(fetch_count_o), 32'd1);
    checkOutput("postreset.pc_const", pc_o, 32'h00400000);

    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 2) begin
        doReset("rnd_reset");
      end else begin
        case ($urandom_range(0, 3))
          0:       target = $urandom;
          1:       target = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
          default: target = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
        applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), target, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
